// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
//   Sequences the hardware-initiated CSR writes of the machine-mode trap path.
//   The trap path covers ecall, illegal instruction, external interrupt entry
//   and mret return. The block owns the single CSR-file write port. It also
//   drives the pipeline stall and the fetch redirect.
//
// Build option:
//   CSR_VECTORED_EN - when defined, interrupt entry with mtvec_in[1:0]==2'b01
//                     jumps to base + 4*cause[30:0]. Otherwise the jump goes
//                     to the base address. When undefined, the mode bits are
//                     ignored.
//
// Ports:
//   clk, rst_n        core clock (rising edge), asynchronous active-low reset
//   inst_valid        inst/pc hold a live instruction this cycle
//   inst, pc          instruction word and its PC
//   illegal_inst      decode flags inst as illegal
//   ext_irq           level machine external interrupt request
//   csr_ex_result     new CSR value from the CSR execute unit
//   mstatus_in        current mstatus (MIE bit 3, MPIE bit 7)
//   mtvec_in          current mtvec
//   mepc_in           current mepc
//   csr_we/waddr/wdata  CSR-file write port
//   stall             freeze fetch/decode (inst/pc must be held)
//   redirect_valid    one-cycle pulse: fetch loads redirect_pc
//   redirect_pc       trap vector or return address
//   busy              sequencer not in IDLE
//   dbg_state         current sequencer state, for observation
//
// Handshake: there is no ready/valid pair here. While stall=1 the upstream
// stage must keep inst/pc/inst_valid stable. A request is accepted only in
// IDLE, in the same cycle it is presented.
module csr_trap_ctrl #(
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic        illegal_inst,
  input  logic        ext_irq,
  input  logic [31:0] csr_ex_result,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_EPC   = 3'd1,
    T_CAUSE = 3'd2,
    T_STAT  = 3'd3,
    T_JUMP  = 3'd4,
    R_STAT  = 3'd5,
    R_JUMP  = 3'd6
  } state_t;

  localparam logic [31:0] CAUSE_IRQ     = 32'h8000000B;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'h00000002;
  localparam logic [31:0] CAUSE_ECALL   = 32'h0000000B;

  state_t      r_state;
  logic [31:0] r_epc;
  logic [31:0] r_cause;

  // mtvec is only read as data here. Its address parameter is kept for
  // documentation of the CSR map.
  logic        w_unused_ok;
  assign w_unused_ok = ^{MTVEC_ADDR, mtvec_in[1:0]};

  // Decode. Everything below is qualified by inst_valid, so an interrupt
  // never enters without a valid PC to save.
  logic        w_ecall, w_mret, w_csr_op, w_irq, w_ill, w_trap;
  logic [2:0]  w_funct3;
  logic [31:0] w_cause;
  logic [31:0] w_base;
  logic [31:0] w_jump_pc;

  assign w_funct3 = inst[14:12];
  assign w_ecall  = inst_valid && (inst == 32'h00000073);
  assign w_mret   = inst_valid && (inst == 32'h30200073);
  assign w_csr_op = inst_valid && (inst[6:0] == 7'b1110011) &&
                    ((w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                     (w_funct3 == 3'b011));
  assign w_irq    = inst_valid && ext_irq && mstatus_in[3];
  assign w_ill    = inst_valid && illegal_inst;
  assign w_trap   = w_irq || w_ill || w_ecall;

  // Priority: enabled interrupt > illegal > ecall. mret is handled after these.
  assign w_cause  = w_irq ? CAUSE_IRQ : (w_ill ? CAUSE_ILLEGAL : CAUSE_ECALL);

  assign w_base   = {mtvec_in[31:2], 2'b00};
`ifdef CSR_VECTORED_EN
  // The vector offset is 4*cause, wrapped to 32 bits.
  assign w_jump_pc = ((mtvec_in[1:0] == 2'b01) && r_cause[31]) ?
                     (w_base + {r_cause[29:0], 2'b00}) : w_base;
`else
  assign w_jump_pc = w_base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_epc   <= 32'h0;
      r_cause <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trap) begin
            r_epc   <= pc;
            r_cause <= w_cause;
            r_state <= T_EPC;
          end else if (w_mret) begin
            r_state <= R_STAT;
          end
        end
        T_EPC:   r_state <= T_CAUSE;
        T_CAUSE: r_state <= T_STAT;
        T_STAT:  r_state <= T_JUMP;
        T_JUMP:  r_state <= IDLE;
        R_STAT:  r_state <= R_JUMP;
        R_JUMP:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The outputs depend on the inputs, because the CSR-instruction write and
  // the request-cycle stall must appear in the same cycle. All outputs are
  // gated by rst_n so that they read 0 while reset is held.
  always_comb begin
    csr_we         = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = 32'h0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (w_trap || w_mret) begin
            // The instruction's own CSR write is dropped when it traps.
            stall = 1'b1;
          end else if (w_csr_op) begin
            csr_we    = 1'b1;
            csr_waddr = inst[31:20];
            csr_wdata = csr_ex_result;
          end
        end
        T_EPC: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = MEPC_ADDR;
          csr_wdata = r_epc;
        end
        T_CAUSE: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = MCAUSE_ADDR;
          csr_wdata = r_cause;
        end
        T_STAT: begin
          // MPIE <= MIE, MIE <= 0 (which blocks nested entry).
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = MSTATUS_ADDR;
          csr_wdata = {mstatus_in[31:8], mstatus_in[3], mstatus_in[6:4],
                       1'b0, mstatus_in[2:0]};
        end
        T_JUMP: begin
          stall          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = w_jump_pc;
        end
        R_STAT: begin
          // MIE <= MPIE, MPIE <= 1.
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = MSTATUS_ADDR;
          csr_wdata = {mstatus_in[31:8], 1'b1, mstatus_in[6:4],
                       mstatus_in[7], mstatus_in[2:0]};
        end
        R_JUMP: begin
          stall          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = mepc_in;
        end
        default: ;
      endcase
    end
  end

  assign busy      = rst_n && (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl. Inputs change 1ns after the rising edge.
// Outputs are checked on the falling edge.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        illegal_inst;
  logic        ext_irq;
  logic [31:0] csr_ex_result;
  logic [31:0] mstatus_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef CSR_VECTORED_EN
  localparam logic [31:0] IRQ_VEC_PC = 32'h0000012C;
`else
  localparam logic [31:0] IRQ_VEC_PC = 32'h00000100;
`endif

  always #5 clk = ~clk;

  csr_trap_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .pc            (pc),
    .illegal_inst  (illegal_inst),
    .ext_irq       (ext_irq),
    .csr_ex_result (csr_ex_result),
    .mstatus_in    (mstatus_in),
    .mtvec_in      (mtvec_in),
    .mepc_in       (mepc_in),
    .csr_we        (csr_we),
    .csr_waddr     (csr_waddr),
    .csr_wdata     (csr_wdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Check all outputs at the falling edge, then advance to just after the next
  // rising edge.
  task automatic cyc(input string tag, input logic we, input logic [11:0] waddr,
                     input logic [31:0] wdata, input logic st, input logic rv,
                     input logic [31:0] rpc, input logic bz);
    @(negedge clk);
    check({tag, ".we"},    {31'h0, csr_we},         {31'h0, we});
    check({tag, ".waddr"}, {20'h0, csr_waddr},      {20'h0, waddr});
    check({tag, ".wdata"}, csr_wdata,               wdata);
    check({tag, ".stall"}, {31'h0, stall},          {31'h0, st});
    check({tag, ".rv"},    {31'h0, redirect_valid}, {31'h0, rv});
    check({tag, ".rpc"},   redirect_pc,             rpc);
    check({tag, ".busy"},  {31'h0, busy},           {31'h0, bz});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_quiet(input string tag);
    inst_valid = 1'b0; ext_irq = 1'b0; illegal_inst = 1'b0;
    cyc(tag, 0, 12'h000, 32'h0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    // Reset is held while a live CSR op is presented. All outputs must stay 0.
    rst_n = 1'b0; inst_valid = 1'b1; inst = 32'h30509073; pc = 32'h0;
    illegal_inst = 1'b0; ext_irq = 1'b0; csr_ex_result = 32'h100;
    mstatus_in = 32'h0; mtvec_in = 32'h100; mepc_in = 32'h0;
    cyc("reset", 0, 12'h000, 32'h0, 0, 0, 32'h0, 0);
    cyc("reset2", 0, 12'h000, 32'h0, 0, 0, 32'h0, 0);
    rst_n = 1'b1;

    // csrrw x0, mtvec, x1: write in the same cycle, no stall.
    cyc("csrrw", 1, 12'h305, 32'h100, 0, 0, 32'h0, 0);
    idle_quiet("csrrw_after");

    // ecall trap entry.
    inst_valid = 1'b1; inst = 32'h00000073; pc = 32'h40;
    mtvec_in = 32'h100; mstatus_in = 32'h8;
    cyc("ecall_req",   0, 12'h000, 32'h0,  1, 0, 32'h0,   0);
    cyc("ecall_epc",   1, 12'h341, 32'h40, 1, 0, 32'h0,   1);
    cyc("ecall_cause", 1, 12'h342, 32'hB,  1, 0, 32'h0,   1);
    cyc("ecall_stat",  1, 12'h300, 32'h80, 1, 0, 32'h0,   1);
    cyc("ecall_jump",  0, 12'h000, 32'h0,  1, 1, 32'h100, 1);
    idle_quiet("ecall_done");

    // mret.
    inst_valid = 1'b1; inst = 32'h30200073; mstatus_in = 32'h80; mepc_in = 32'h44;
    cyc("mret_req",  0, 12'h000, 32'h0,  1, 0, 32'h0,  0);
    cyc("mret_stat", 1, 12'h300, 32'h88, 1, 0, 32'h0,  1);
    cyc("mret_jump", 0, 12'h000, 32'h0,  1, 1, 32'h44, 1);
    idle_quiet("mret_done");

    // An enabled interrupt with no valid instruction is not taken.
    ext_irq = 1'b1; mstatus_in = 32'h8;
    cyc("irq_novalid", 0, 12'h000, 32'h0, 0, 0, 32'h0, 0);

    // With the interrupt masked (MIE=0), csrrs executes normally.
    inst_valid = 1'b1; inst = 32'h3000A073; csr_ex_result = 32'h55;
    mstatus_in = 32'h0; pc = 32'h80;
    cyc("irq_masked", 1, 12'h300, 32'h55, 0, 0, 32'h0, 0);

    // MIE=1: the interrupt is taken and the csrrs write is suppressed.
    mstatus_in = 32'h8; mtvec_in = 32'h101;
    cyc("irq_req",   0, 12'h000, 32'h0,        1, 0, 32'h0,      0);
    ext_irq = 1'b0;  // a change mid-sequence has no effect
    cyc("irq_epc",   1, 12'h341, 32'h80,       1, 0, 32'h0,      1);
    cyc("irq_cause", 1, 12'h342, 32'h8000000B, 1, 0, 32'h0,      1);
    cyc("irq_stat",  1, 12'h300, 32'h80,       1, 0, 32'h0,      1);
    cyc("irq_jump",  0, 12'h000, 32'h0,        1, 1, IRQ_VEC_PC, 1);
    idle_quiet("irq_done");

    // Interrupt and illegal together: the interrupt wins.
    inst_valid = 1'b1; inst = 32'h0; illegal_inst = 1'b1; ext_irq = 1'b1;
    pc = 32'hC0; mtvec_in = 32'h200; mstatus_in = 32'h8;
    cyc("both_req",   0, 12'h000, 32'h0,        1, 0, 32'h0,   0);
    cyc("both_epc",   1, 12'h341, 32'hC0,       1, 0, 32'h0,   1);
    cyc("both_cause", 1, 12'h342, 32'h8000000B, 1, 0, 32'h0,   1);
    cyc("both_stat",  1, 12'h300, 32'h80,       1, 0, 32'h0,   1);
    cyc("both_jump",  0, 12'h000, 32'h0,        1, 1, 32'h200, 1);
    idle_quiet("both_done");

    // Illegal alone. mstatus has MPIE set and MIE clear.
    inst_valid = 1'b1; illegal_inst = 1'b1; pc = 32'hC4; mstatus_in = 32'h80;
    cyc("ill_req",   0, 12'h000, 32'h0,  1, 0, 32'h0,   0);
    cyc("ill_epc",   1, 12'h341, 32'hC4, 1, 0, 32'h0,   1);
    cyc("ill_cause", 1, 12'h342, 32'h2,  1, 0, 32'h0,   1);
    cyc("ill_stat",  1, 12'h300, 32'h0,  1, 0, 32'h0,   1);
    cyc("ill_jump",  0, 12'h000, 32'h0,  1, 1, 32'h200, 1);
    idle_quiet("ill_done");

    // Reset asserted during T_CAUSE.
    inst_valid = 1'b1; inst = 32'h00000073; pc = 32'h100;
    mstatus_in = 32'h8; mtvec_in = 32'h100;
    cyc("rst_req", 0, 12'h000, 32'h0,   1, 0, 32'h0, 0);
    cyc("rst_epc", 1, 12'h341, 32'h100, 1, 0, 32'h0, 1);
    rst_n = 1'b0;
    cyc("rst_mid", 0, 12'h000, 32'h0, 0, 0, 32'h0, 0);
    rst_n = 1'b1;
    idle_quiet("rst_idle");

    // A full sequence after the reset.
    inst_valid = 1'b1; inst = 32'h00000073; pc = 32'h104;
    cyc("post_req",   0, 12'h000, 32'h0,   1, 0, 32'h0,   0);
    cyc("post_epc",   1, 12'h341, 32'h104, 1, 0, 32'h0,   1);
    cyc("post_cause", 1, 12'h342, 32'hB,   1, 0, 32'h0,   1);
    cyc("post_stat",  1, 12'h300, 32'h80,  1, 0, 32'h0,   1);
    cyc("post_jump",  0, 12'h000, 32'h0,   1, 1, 32'h100, 1);
    idle_quiet("post_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
